// File: rtl/ram_arbiter_if.sv
// Bundles the two requester ports and the shared ram port of ram_arbiter.
// The master modport is the arbiter's view; slave is the requesters and the ram.
interface ram_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          done0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          done1;
  logic [DW-1:0] rdata1;

  logic          ram_read;
  logic          ram_write;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport master (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_rdata,
    output done0, rdata0, done1, rdata1,
    output ram_read, ram_write, ram_addr, ram_wdata
  );

  modport slave (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_rdata,
    input  done0, rdata0, done1, rdata1,
    input  ram_read, ram_write, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the single data-memory port: IDLE -> ACCESS -> DONE.
// Define ARB_RR_EN for round-robin tie-breaking; default build uses fixed priority (port 0).
module ram_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        state;
  logic          cmd_owner;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          read_q;
  logic          write_q;
  logic          done0_q;
  logic          done1_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  logic          grant;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

`ifdef ARB_RR_EN
  logic last_owner;

  always_comb begin
    grant = 1'b0;
    if (bus.req0 && bus.req1) grant = ~last_owner;
    else if (bus.req1)        grant = 1'b1;
  end
`else
  always_comb begin
    grant = ~bus.req0;
  end
`endif

  always_comb begin
    sel_we    = grant ? bus.we1    : bus.we0;
    sel_addr  = grant ? bus.addr1  : bus.addr0;
    sel_wdata = grant ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_owner <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
`ifdef ARB_RR_EN
      last_owner <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req0 || bus.req1) begin
            cmd_owner <= grant;
            cmd_we    <= sel_we;
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
            read_q    <= ~sel_we;
            write_q   <= sel_we;
            state     <= S_ACCESS;
`ifdef ARB_RR_EN
            last_owner <= grant;
`endif
          end
        end
        S_ACCESS: begin
          read_q  <= 1'b0;
          write_q <= 1'b0;
          if (!cmd_we) begin
            if (cmd_owner) rdata1_q <= bus.ram_rdata;
            else           rdata0_q <= bus.ram_rdata;
          end
          done0_q <= ~cmd_owner;
          done1_q <= cmd_owner;
          state   <= S_DONE;
        end
        S_DONE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are gated by rst so a reset landing in ACCESS never commits the write.
  assign bus.ram_read  = read_q  & ~rst;
  assign bus.ram_write = write_q & ~rst;
  assign bus.ram_addr  = cmd_addr;
  assign bus.ram_wdata = cmd_wdata;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic checked against
// a transaction-level model (grant rule, fixed 3-cycle occupancy, word memory image).
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.AW(32), .DW(32)) bus ();

  ram_arbiter #(.AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Requester drive state
  logic        req_d   [2] = '{1'b0, 1'b0};
  logic        we_d    [2] = '{1'b0, 1'b0};
  logic [31:0] addr_d  [2] = '{32'h0, 32'h0};
  logic [31:0] wdata_d [2] = '{32'h0, 32'h0};

  assign bus.req0   = req_d[0];
  assign bus.we0    = we_d[0];
  assign bus.addr0  = addr_d[0];
  assign bus.wdata0 = wdata_d[0];
  assign bus.req1   = req_d[1];
  assign bus.we1    = we_d[1];
  assign bus.addr1  = addr_d[1];
  assign bus.wdata1 = wdata_d[1];

  // Environment ram: combinational read, write on clock edge
  logic [31:0] mem [16] = '{7: 32'h12345678, default: 32'h0};
  assign bus.ram_rdata = mem[bus.ram_addr[3:0]];
  always @(posedge clk) if (bus.ram_write) mem[bus.ram_addr[3:0]] <= bus.ram_wdata;

  // Reference model state
  logic [31:0] ref_mem [16] = '{7: 32'h12345678, default: 32'h0};
  logic [31:0] exp_rdata [2] = '{32'h0, 32'h0};
  bit          pending [2] = '{1'b0, 1'b0};
  bit          active = 1'b0;
  int unsigned t_owner, g, next_free, cyc, m_last;
  bit          t_we;
  logic [31:0] t_addr, t_wdata;
  int unsigned done_log [$];

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic issue(input int unsigned p, input bit we, input logic [31:0] a, input logic [31:0] d);
    pending[p] = 1'b1;
    req_d[p]   = 1'b1;
    we_d[p]    = we;
    addr_d[p]  = a;
    wdata_d[p] = d;
  endtask

  // One negedge: compare DUT outputs against what the model expects for this cycle.
  task automatic tick_check();
    logic       exp_rd, exp_wr;
    logic [1:0] exp_done;
    @(negedge clk);
    cyc++;
    exp_rd = 1'b0; exp_wr = 1'b0; exp_done = 2'b00;
    if (bus.done0) done_log.push_back(0);
    if (bus.done1) done_log.push_back(1);
    if (active && cyc == g + 1) begin
      exp_rd = ~t_we;
      exp_wr = t_we;
      check("ram_addr", bus.ram_addr, t_addr);
      if (t_we) check("ram_wdata", bus.ram_wdata, t_wdata);
    end
    if (active && cyc == g + 2) begin
      exp_done[t_owner] = 1'b1;
      if (t_we) ref_mem[t_addr[3:0]] = t_wdata;
      else      exp_rdata[t_owner] = ref_mem[t_addr[3:0]];
      active = 1'b0;
      pending[t_owner] = 1'b0;
      req_d[t_owner] = 1'b0;
    end
    check("ram_read",  {31'b0, bus.ram_read},  {31'b0, exp_rd});
    check("ram_write", {31'b0, bus.ram_write}, {31'b0, exp_wr});
    check("done0",     {31'b0, bus.done0},     {31'b0, exp_done[0]});
    check("done1",     {31'b0, bus.done1},     {31'b0, exp_done[1]});
    check("rdata0",    bus.rdata0, exp_rdata[0]);
    check("rdata1",    bus.rdata1, exp_rdata[1]);
  endtask

  // Grant decision on the request inputs the DUT samples at the coming posedge.
  task automatic arbitrate();
    int unsigned p;
    if (rst || active || cyc < next_free || !(req_d[0] || req_d[1])) return;
    if (req_d[0] && req_d[1]) begin
`ifdef ARB_RR_EN
      p = (m_last == 0) ? 1 : 0;
`else
      p = 0;
`endif
    end else begin
      p = req_d[1] ? 1 : 0;
    end
    active    = 1'b1;
    g         = cyc;
    t_owner   = p;
    t_we      = we_d[p];
    t_addr    = addr_d[p];
    t_wdata   = wdata_d[p];
    m_last    = p;
    next_free = cyc + 3;
  endtask

  task automatic apply_reset(input int unsigned n);
    rst = 1'b1;
    active = 1'b0;
    pending = '{1'b0, 1'b0};
    req_d = '{1'b0, 1'b0};
    exp_rdata = '{32'h0, 32'h0};
    m_last = 1;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
    end
    rst = 1'b0;
    next_free = cyc;
  endtask

  task automatic wait_idle();
    for (int unsigned i = 0; i < 30 && (active || pending[0] || pending[1]); i++) begin
      tick_check();
      arbitrate();
    end
    check("drain", {31'b0, active || pending[0] || pending[1]}, 32'h0);
  endtask

  initial begin
    cyc = 0; g = 0; next_free = 0; m_last = 1; t_owner = 0;
    t_we = 1'b0; t_addr = '0; t_wdata = '0;

    // Reset state
    apply_reset(2);
    tick_check(); arbitrate();

    // Port 0 write then read of address 5
    tick_check(); issue(0, 1'b1, 32'd5, 32'hDEADBEEF); arbitrate();
    wait_idle();
    tick_check(); issue(0, 1'b0, 32'd5, 32'h0); arbitrate();
    wait_idle();
    check("t2_rdata0", bus.rdata0, 32'hDEADBEEF);

    // Port 1 read of preloaded address 7
    tick_check(); issue(1, 1'b0, 32'd7, 32'h0); arbitrate();
    wait_idle();
    check("t3_rdata1", bus.rdata1, 32'h12345678);
    check("t3_rdata0", bus.rdata0, 32'hDEADBEEF);

    // Both ports requesting continuously
    done_log.delete();
    tick_check(); issue(0, 1'b0, 32'd1, 32'h0); issue(1, 1'b0, 32'd2, 32'h0); arbitrate();
    for (int unsigned i = 0; i < 40 && done_log.size() < 4; i++) begin
      tick_check();
      if (done_log.size() < 4) begin
        if (!pending[0]) issue(0, 1'b0, 32'd1, 32'h0);
        if (!pending[1]) issue(1, 1'b0, 32'd2, 32'h0);
      end
      arbitrate();
    end
    check("t4_count", done_log.size(), 32'd4);
    for (int unsigned i = 0; i < 4 && i < done_log.size(); i++) begin
`ifdef ARB_RR_EN
      check("t4_order", done_log[i], i % 2);
`else
      check("t4_order", done_log[i], 32'd0);
`endif
    end
    wait_idle();

    // Port 0 drops its request during ACCESS
    done_log.delete();
    tick_check(); issue(0, 1'b0, 32'd3, 32'h0); arbitrate();
    tick_check(); req_d[0] = 1'b0; arbitrate();
    for (int unsigned i = 0; i < 6; i++) begin tick_check(); arbitrate(); end
    check("t6_dones", done_log.size(), 32'd1);

    // Reset during ACCESS of a write to address 9
    done_log.delete();
    tick_check(); issue(0, 1'b1, 32'd9, 32'hCAFEF00D); arbitrate();
    tick_check(); apply_reset(2);
    tick_check(); issue(1, 1'b0, 32'd9, 32'h0); arbitrate();
    wait_idle();
    check("t5_rdata1", bus.rdata1, 32'h0);
    check("t5_dones", done_log.size(), 32'd1);

    // Randomized traffic
    for (int unsigned i = 0; i < 600; i++) begin
      tick_check();
      if (active && cyc == g + 1 && $urandom_range(3) == 0) req_d[t_owner] = 1'b0;
      for (int unsigned p = 0; p < 2; p++) begin
        if (!pending[p] && $urandom_range(9) < 6)
          issue(p, 1'($urandom_range(1)), 32'($urandom_range(15)), $urandom);
      end
      arbitrate();
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
